register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port integer register file for the decode stage. It provides `NUM_READ` combinational read ports and `NUM_WRITE` synchronous write ports, with register 0 hardwired to zero. A pending-write scoreboard lets hazard logic see which registers still await writeback. After reset, an initialisation sequencer zeroes the array one entry per cycle instead of resetting the whole storage array.

## Interface

**Parameters**
- `XLEN`, 32: data width.
- `DEPTH`, 32: number of registers; power of two, ≥ 2.
- `NUM_READ`, 2: read ports, 1–4.
- `NUM_WRITE`, 2: write ports, 1–2.
- Derived constant `AW = $clog2(DEPTH)`.

**Ports**
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ready`  out  1  high once initialisation is complete.
- `readAddr`  in  NUM_READ*AW  packed read addresses; port i is slice i.
- `readData`  out  NUM_READ*XLEN  packed read data.
- `readBusy`  out  NUM_READ  scoreboard pending bit of each addressed register.
- `writeEnable`  in  NUM_WRITE  per-port write strobe.
- `writeAddr`  in  NUM_WRITE*AW  packed write addresses.
- `writeData`  in  NUM_WRITE*XLEN  packed write data.
- `issueValid`  in  1  an instruction with destination `issueRd` issues this cycle.
- `issueRd`  in  AW  destination register to mark pending.
- `flush`  in  1  clears all pending bits.

## Operation

- **FSM states:** INIT and RUN.
  - `reset` high forces INIT, `clearIndex` = 0, `ready` = 0, and all pending bits = 0.
  - In INIT, each edge writes zero to `regFile[clearIndex]` and increments `clearIndex`.
  - On the edge that clears index DEPTH-1, the FSM moves to RUN and `ready` goes to 1.
- **During INIT:**
  - Writes, issues and flushes are ignored.
  - `readData` is forced to 0 and `readBusy` is forced to 0.
- **Register 0:**
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - An issue to address 0 sets no pending bit.
- **Writes:**
  - On each edge, every enabled port with a nonzero address updates its entry.
  - If two ports target the same address in the same cycle, the higher-index port wins.
- **Scoreboard:**
  - A write to address a clears `pending[a]`.
  - `issueValid` sets `pending[issueRd]`.
  - If an issue and a write target the same address in one cycle, set wins, because the issue is the newer producer.
  - `flush` clears all bits. If `flush` and an issue occur in the same cycle, flush wins and the issue is dropped.
- **Reads:** `readData` and `readBusy` are combinational functions of the address and current state.
- **Reset mid-operation:** the FSM returns immediately to INIT, `ready` drops, and the array is re-zeroed over `DEPTH` cycles.

## Timing

- Write-to-read latency is 1 cycle without bypass and 0 cycles with bypass (see Configuration).
- Issue-to-busy latency is 1 cycle: `readBusy` reflects an issue on the edge after it.
- Initialisation latency:
  - `ready` rises exactly `DEPTH` rising edges after `reset` deasserts.
  - If `reset` deasserts within setup/hold of an edge, that edge may or may not count.
- Reset values: `ready` = 0, `readData` = 0, `readBusy` = 0.

## Configuration

- Macro `REGFILE_BYPASS_EN` enables write-to-read forwarding.
- **Defined:**
  - When a read address matches an enabled write address (nonzero), `readData` returns the winning port's `writeData` in the same cycle.
  - `readBusy` reads 0 for that address unless `issueValid` targets it in the same cycle.
- **Undefined:**
  - Reads return the stored value and `readBusy` reflects the stored pending bit.
  - A new value becomes visible on the cycle after the write.

## Structure

- **Package `regfile_pkg`:**
  - State enum `rf_state_t` {RF_INIT, RF_RUN}.
  - Default parameter constants and the port-limit constants.
- **Sub-module `regfile_scoreboard`:**
  - Owns the `DEPTH`-bit pending vector and the set/clear/flush priority.
  - Provides the per-read-port busy lookups.
- **Top level:** the array, write arbitration, bypass muxing and the init FSM.

## Test plan

- **Init:** assert reset, release, and read addresses 5 and 31 every cycle. Required: `ready` = 0 and `readData` = 0 for 32 cycles, then `ready` = 1 with both reads 0.
- **Write/read:** write 0xDEADBEEF to r7 on port 0, then read r7 the next cycle. Required: 0xDEADBEEF. Also write 0x1234 to r0 and read r0. Required: 0.
- **Port conflict:** in one cycle, port 0 writes 0x11 to r9 and port 1 writes 0x22 to r9. Required: r9 reads 0x22.
- **Scoreboard:**
  - Issue r3; required: `readBusy` = 1 on the next cycle.
  - Write r3; required: busy = 0.
  - Issue r4 and flush in the same cycle; required: r4 busy = 0.
  - Issue r6 and write r6 in the same cycle; required: r6 busy = 1.
- **Bypass:** write 0xA5 to r12 while reading r12 in the same cycle. Required: 0xA5 with `REGFILE_BYPASS_EN` defined; the old value without it.
- **Reset mid-run:**
  - Write 0x55 to r2, then pulse reset.
  - Required: `ready` falls asynchronously and r2 reads 0 after re-init.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared types and constants for the multi-port register file.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  // Initialisation sequencer states
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  // Default configuration
  localparam int RF_DEF_XLEN      = 32;
  localparam int RF_DEF_DEPTH     = 32;
  localparam int RF_DEF_NUM_READ  = 2;
  localparam int RF_DEF_NUM_WRITE = 2;

  // Supported port-count limits
  localparam int RF_MAX_READ  = 4;
  localparam int RF_MAX_WRITE = 2;

endpackage

`default_nettype wire

// File: rtl/register_file_mp_if.sv
// ============================================================================
// Module  : register_file_mp_if
// Purpose : Read/write/issue bus of the register file. The decode stage is the
//           master; the register file is the slave.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_file_mp_if #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                      ready;
  logic [NUM_READ*AW-1:0]    readAddr;
  logic [NUM_READ*XLEN-1:0]  readData;
  logic [NUM_READ-1:0]       readBusy;
  logic [NUM_WRITE-1:0]      writeEnable;
  logic [NUM_WRITE*AW-1:0]   writeAddr;
  logic [NUM_WRITE*XLEN-1:0] writeData;
  logic                      issueValid;
  logic [AW-1:0]             issueRd;
  logic                      flush;

  modport master (
    input  ready, readData, readBusy,
    output readAddr, writeEnable, writeAddr, writeData, issueValid, issueRd, flush
  );

  modport slave (
    input  readAddr, writeEnable, writeAddr, writeData, issueValid, issueRd, flush,
    output ready, readData, readBusy
  );

endinterface

`default_nettype wire

// File: rtl/register_file_mp_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Purpose : Pending-write bit per register. Priority on one edge:
//           flush > issue set > writeback clear.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEF_DEPTH,
  parameter int NUM_READ = RF_DEF_NUM_READ,
  parameter int AW       = $clog2(DEPTH)
) (
  input  wire logic                   clock,
  input  wire logic                   reset,
  input  wire logic                   i_run,
  input  wire logic                   i_flush,
  input  wire logic                   i_issueValid,
  input  wire logic [AW-1:0]          i_issueRd,
  input  wire logic [DEPTH-1:0]       i_clear,
  input  wire logic [NUM_READ*AW-1:0] i_readAddr,
  output logic      [NUM_READ-1:0]    o_busy
);

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pendingNext;

  // Next pending vector; register 0 never becomes pending
  always_comb begin
    w_pendingNext = r_pending;
    if (i_run) begin
      if (i_flush) begin
        w_pendingNext = '0;
      end else begin
        w_pendingNext = r_pending & ~i_clear;
        if (i_issueValid && (i_issueRd != '0)) begin
          w_pendingNext[i_issueRd] = 1'b1;
        end
      end
    end
  end

  // Pending vector register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pendingNext;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    assign o_busy[i] = r_pending[i_readAddr[i*AW +: AW]];
  end

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// ============================================================================
// Module  : register_file_mp
// Purpose : Multi-port integer register file with r0 hardwired to zero, a
//           pending-write scoreboard and a post-reset zeroing sequencer.
//           Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to
//           the read ports.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = RF_DEF_XLEN,
  parameter int DEPTH     = RF_DEF_DEPTH,
  parameter int NUM_READ  = RF_DEF_NUM_READ,
  parameter int NUM_WRITE = RF_DEF_NUM_WRITE
) (
  input wire logic clock,
  input wire logic reset,
  register_file_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  if (NUM_READ < 1 || NUM_READ > RF_MAX_READ) begin : g_bad_read
    $error("register_file_mp: NUM_READ out of range");
  end
  if (NUM_WRITE < 1 || NUM_WRITE > RF_MAX_WRITE) begin : g_bad_write
    $error("register_file_mp: NUM_WRITE out of range");
  end

  rf_state_t        r_state;
  rf_state_t        w_stateNext;
  logic [AW-1:0]    r_clearIndex;
  logic [AW-1:0]    w_clearIndexNext;
  logic             w_run;
  logic [XLEN-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0] w_clear;
  logic [NUM_READ-1:0] w_sbBusy;

  assign w_run     = (r_state == RF_RUN);
  assign bus.ready = w_run;

  // Init sequencer state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= RF_INIT;
      r_clearIndex <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_clearIndex <= w_clearIndexNext;
    end
  end

  // Init sequencer next state: step through every index, then run
  always_comb begin
    w_stateNext      = r_state;
    w_clearIndexNext = r_clearIndex;
    case (r_state)
      RF_INIT: begin
        w_clearIndexNext = r_clearIndex + 1'b1;
        if (r_clearIndex == AW'(DEPTH - 1)) begin
          w_stateNext = RF_RUN;
        end
      end
      default: begin
        w_stateNext = RF_RUN;
      end
    endcase
  end

  // Storage array: zeroed one entry per cycle during init, otherwise written
  // by the ports in ascending order so the highest-index port wins a conflict
  always_ff @(posedge clock) begin
    if (!w_run) begin
      r_regs[r_clearIndex] <= '0;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (bus.writeEnable[p] && (bus.writeAddr[p*AW +: AW] != '0)) begin
          r_regs[bus.writeAddr[p*AW +: AW]] <= bus.writeData[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Registers receiving a writeback this cycle, for scoreboard clearing
  always_comb begin
    w_clear = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (bus.writeEnable[p] && (bus.writeAddr[p*AW +: AW] != '0)) begin
        w_clear[bus.writeAddr[p*AW +: AW]] = 1'b1;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ),
    .AW       (AW)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .i_run        (w_run),
    .i_flush      (bus.flush),
    .i_issueValid (bus.issueValid),
    .i_issueRd    (bus.issueRd),
    .i_clear      (w_clear),
    .i_readAddr   (bus.readAddr),
    .o_busy       (w_sbBusy)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;
    logic            w_hit;

    assign w_addr = bus.readAddr[i*AW +: AW];

    // Read mux: stored value, optionally overridden by a same-cycle write
    always_comb begin
      w_data = r_regs[w_addr];
      w_hit  = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (bus.writeEnable[p] && (bus.writeAddr[p*AW +: AW] == w_addr)) begin
          w_hit  = 1'b1;
          w_data = bus.writeData[p*XLEN +: XLEN];
        end
      end
`endif
      // A forwarded register is only busy if a newer producer issues now
      w_busy = w_hit ? (bus.issueValid && !bus.flush && (bus.issueRd == w_addr))
                     : w_sbBusy[i];
      if (!w_run || (w_addr == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign bus.readData[i*XLEN +: XLEN] = w_data;
    assign bus.readBusy[i]              = w_busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// ============================================================================
// Module  : tb_register_file_mp
// Purpose : Directed and random checks of register_file_mp against an
//           array-based reference model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = 5;

  logic clock;
  logic reset;

  register_file_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();

  register_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [XLEN-1:0] mem [DEPTH];
  bit              pend [DEPTH];
  bit              mready;
  int              mcnt;

  function automatic int waddr(int p);
    return int'(bus.writeAddr[p*AW +: AW]);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int a);
    logic [XLEN-1:0] r;
    if (!mready || a == 0) return '0;
    r = mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++)
      if (bus.writeEnable[p] && waddr(p) == a) r = bus.writeData[p*XLEN +: XLEN];
`endif
    return r;
  endfunction

  function automatic logic exp_busy(int a);
    if (!mready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++)
      if (bus.writeEnable[p] && waddr(p) == a)
        return bus.issueValid && !bus.flush && int'(bus.issueRd) == a;
`endif
    return pend[a];
  endfunction

  task automatic model_reset();
    mready = 0;
    mcnt   = 0;
    for (int k = 0; k < DEPTH; k++) pend[k] = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (!mready) begin
      mcnt++;
      if (mcnt == DEPTH) begin
        mready = 1;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
      end
    end else begin
      for (int p = 0; p < NW; p++)
        if (bus.writeEnable[p] && waddr(p) != 0) mem[waddr(p)] = bus.writeData[p*XLEN +: XLEN];
      if (bus.flush) begin
        for (int k = 0; k < DEPTH; k++) pend[k] = 0;
      end else begin
        for (int p = 0; p < NW; p++)
          if (bus.writeEnable[p] && waddr(p) != 0) pend[waddr(p)] = 0;
        if (bus.issueValid && bus.issueRd != '0) pend[bus.issueRd] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: check outputs, advance one rising edge, return at next falling edge
  task automatic cycle();
    #1;
    chk("ready", {31'b0, bus.ready}, {31'b0, mready});
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rdata%0d", i), bus.readData[i*XLEN +: XLEN],
          exp_data(int'(bus.readAddr[i*AW +: AW])));
      chk($sformatf("rbusy%0d", i), {31'b0, bus.readBusy[i]},
          {31'b0, exp_busy(int'(bus.readAddr[i*AW +: AW]))});
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.writeEnable = '0;
    bus.writeAddr   = '0;
    bus.writeData   = '0;
    bus.issueValid  = 1'b0;
    bus.issueRd     = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.readAddr[0 +: AW]  = AW'(a0);
    bus.readAddr[AW +: AW] = AW'(a1);
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    bus.writeEnable[p]          = 1'b1;
    bus.writeAddr[p*AW +: AW]   = AW'(a);
    bus.writeData[p*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input int a, input bit fl);
    bus.issueValid = 1'b1;
    bus.issueRd    = AW'(a);
    bus.flush      = fl;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_rd(5, 31);
    model_reset();
    @(negedge clock);
    cycle();
    cycle();

    // Init: ready low and reads zero for DEPTH edges, then ready
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk("init_ready", {31'b0, bus.ready}, 32'h0);
      chk("init_r5", bus.readData[0 +: XLEN], 32'h0);
      cycle();
    end
    #1;
    chk("ready_up", {31'b0, bus.ready}, 32'h1);
    cycle();

    // Write/read r7, write r0
    set_wr(0, 7, 32'hDEADBEEF);
    cycle();
    idle();
    set_rd(7, 0);
    #1;
    chk("r7", bus.readData[0 +: XLEN], 32'hDEADBEEF);
    cycle();
    set_wr(0, 0, 32'h1234);
    cycle();
    idle();
    #1;
    chk("r0", bus.readData[XLEN +: XLEN], 32'h0);
    cycle();

    // Port conflict on r9
    set_wr(0, 9, 32'h11);
    set_wr(1, 9, 32'h22);
    cycle();
    idle();
    set_rd(9, 9);
    #1;
    chk("r9_conflict", bus.readData[0 +: XLEN], 32'h22);
    cycle();

    // Scoreboard
    set_rd(3, 4);
    issue(3, 0);
    cycle();
    idle();
    #1;
    chk("r3_busy", {31'b0, bus.readBusy[0]}, 32'h1);
    cycle();
    set_wr(0, 3, 32'h33);
    cycle();
    idle();
    #1;
    chk("r3_clear", {31'b0, bus.readBusy[0]}, 32'h0);
    cycle();
    issue(4, 1);
    cycle();
    idle();
    #1;
    chk("r4_flush", {31'b0, bus.readBusy[1]}, 32'h0);
    cycle();
    set_rd(6, 6);
    issue(6, 0);
    set_wr(1, 6, 32'h66);
    cycle();
    idle();
    #1;
    chk("r6_setwins", {31'b0, bus.readBusy[0]}, 32'h1);
    cycle();

    // Bypass on r12
    set_wr(0, 12, 32'h77);
    cycle();
    idle();
    set_rd(12, 12);
    set_wr(0, 12, 32'hA5);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r12_bypass", bus.readData[0 +: XLEN], 32'hA5);
`else
    chk("r12_bypass", bus.readData[0 +: XLEN], 32'h77);
`endif
    cycle();
    idle();
    cycle();

    // Random traffic biased to a few registers to create collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      set_rd($urandom_range(0, 7), $urandom_range(0, 7));
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) issue($urandom_range(0, 7), 0);
      if ($urandom_range(0, 15) == 0) bus.flush = 1'b1;
      cycle();
    end
    idle();

    // Reset mid-run
    set_wr(0, 2, 32'h55);
    cycle();
    idle();
    set_rd(2, 2);
    cycle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ready_async_fall", {31'b0, bus.ready}, 32'h0);
    @(negedge clock);
    cycle();
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) cycle();
    #1;
    chk("r2_rezeroed", bus.readData[0 +: XLEN], 32'h0);
    chk("ready_again", {31'b0, bus.ready}, 32'h1);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
